// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder and its sibling decoder:
// format indices, one-hot format codes, base opcodes, the field bundle type
// and small helper functions.
package inst_encoder_pkg;

  // Format index positions inside the one-hot format vector.
  localparam int FMT_W = 6;
  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  // One-hot format codes.
  localparam logic [FMT_W-1:0] FMT_OH_R = 6'b000001;
  localparam logic [FMT_W-1:0] FMT_OH_I = 6'b000010;
  localparam logic [FMT_W-1:0] FMT_OH_S = 6'b000100;
  localparam logic [FMT_W-1:0] FMT_OH_B = 6'b001000;
  localparam logic [FMT_W-1:0] FMT_OH_U = 6'b010000;
  localparam logic [FMT_W-1:0] FMT_OH_J = 6'b100000;

  // RV32I base opcodes.
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Field bundle carried from stage 1 into the stage-2 word assembly.
  typedef struct packed {
    logic [FMT_W-1:0] fmt;
    logic [6:0]       funct7;
    logic [4:0]       rs2;
    logic [4:0]       rs1;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [6:0]       opcode;
    logic [31:0]      imm;
  } inst_fields_t;

  // True when exactly one bit of the format vector is set.
  function automatic logic fmt_is_onehot(input logic [FMT_W-1:0] fmt);
    return (fmt != 6'b000000) && ((fmt & (fmt - 6'b000001)) == 6'b000000);
  endfunction

  // True when the masked bits of v are all zero or all one, i.e. the value
  // is a correct sign extension over the masked range.
  function automatic logic bits_uniform(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'h0000_0000) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Purely combinational field-to-word assembly for the six RV32I formats.
// Any format code that is not one of the six one-hot values falls back to
// the R layout so that malformed bundles still produce a defined word.
module inst_encoder_pack
  import inst_encoder_pkg::*;
(
  input  logic [FMT_W-1:0] fmt_i,
  input  logic [6:0]       funct7_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rs1_i,
  input  logic [2:0]       funct3_i,
  input  logic [4:0]       rd_i,
  input  logic [6:0]       opcode_i,
  input  logic [31:0]      imm_i,
  output logic [31:0]      inst_o
);

  // Scatter the immediate and register fields into the layout of the format.
  always_comb begin
    inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    case (fmt_i)
      FMT_OH_R: inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_OH_I: inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_OH_S: inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_OH_B: inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
      FMT_OH_U: inst_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_OH_J: inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default:  inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder.
// Stage 1 registers the field bundle and its error flag, stage 2 holds the
// assembled word. Output counters track emitted words and erroneous words.
// Build option: define INST_ENCODER_RANGE_CHECK_EN to also flag immediates
// that cannot be represented in the selected format.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [FMT_W-1:0] i_format,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic             o_err,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_err_count
);

  // Stage 1 state.
  logic         s1_valid_q;
  inst_fields_t s1_fields_q;
  inst_fields_t s1_fields_d;
  logic         s1_err_q;
  logic         s1_err_d;

  // Stage 2 state.
  logic         s2_valid_q;
  logic [31:0]  s2_inst_q;
  logic         s2_err_q;
  logic [31:0]  pack_inst_s;

  // Counters.
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_d;

  // Handshake terms.
  logic s2_adv_s;
  logic in_xfer_s;
  logic out_xfer_s;
  logic fmt_ok_s;
  logic range_err_s;

  assign s2_adv_s   = !s2_valid_q || i_ready;
  assign o_ready    = !s1_valid_q || s2_adv_s;
  assign in_xfer_s  = i_valid && o_ready;
  assign out_xfer_s = s2_valid_q && i_ready;
  assign fmt_ok_s   = fmt_is_onehot(i_format);

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // Flag immediates whose significant bits do not fit the chosen format.
  always_comb begin
    range_err_s = 1'b0;
    case (i_format)
      FMT_OH_I: range_err_s = !bits_uniform(i_imm, 32'hFFFF_F800);
      FMT_OH_S: range_err_s = !bits_uniform(i_imm, 32'hFFFF_F800);
      FMT_OH_B: range_err_s = !bits_uniform(i_imm, 32'hFFFF_F000) || i_imm[0];
      FMT_OH_U: range_err_s = (i_imm[11:0] != 12'h000);
      FMT_OH_J: range_err_s = !bits_uniform(i_imm, 32'hFFF0_0000) || i_imm[0];
      default:  range_err_s = 1'b0;
    endcase
  end
`else
  assign range_err_s = 1'b0;
`endif

  // Capture the incoming bundle; a malformed format is replaced by R so the
  // word falls back to the R layout.
  always_comb begin
    s1_fields_d.fmt    = fmt_ok_s ? i_format : FMT_OH_R;
    s1_fields_d.funct7 = i_funct7;
    s1_fields_d.rs2    = i_rs2;
    s1_fields_d.rs1    = i_rs1;
    s1_fields_d.funct3 = i_funct3;
    s1_fields_d.rd     = i_rd;
    s1_fields_d.opcode = i_opcode;
    s1_fields_d.imm    = i_imm;
    s1_err_d           = !fmt_ok_s || range_err_s;
  end

  inst_encoder_pack u_pack (
    .fmt_i    (s1_fields_q.fmt),
    .funct7_i (s1_fields_q.funct7),
    .rs2_i    (s1_fields_q.rs2),
    .rs1_i    (s1_fields_q.rs1),
    .funct3_i (s1_fields_q.funct3),
    .rd_i     (s1_fields_q.rd),
    .opcode_i (s1_fields_q.opcode),
    .imm_i    (s1_fields_q.imm),
    .inst_o   (pack_inst_s)
  );

  // Next counter values: wrapping word count, saturating error count.
  always_comb begin
    count_d     = count_q;
    err_count_d = err_count_q;
    if (out_xfer_s) begin
      count_d = count_q + CNT_W'(1);
      if (s2_err_q && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      count_d     = count_q;
      err_count_d = err_count_q;
    end
  end

  // Stage 1 register: load on input transfer, empty when its word moves on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fields_q <= '0;
      s1_err_q    <= 1'b0;
    end else if (in_xfer_s) begin
      s1_valid_q  <= 1'b1;
      s1_fields_q <= s1_fields_d;
      s1_err_q    <= s1_err_d;
    end else if (s2_adv_s) begin
      s1_valid_q  <= 1'b0;
    end
  end

  // Stage 2 register: take the assembled word whenever the output can move;
  // the word and its error flag hold while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= 32'h0000_0000;
      s2_err_q   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= pack_inst_s;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  // Output transfer counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_inst      = s2_inst_q;
  assign o_err       = s2_err_q;
  assign o_count     = count_q;
  assign o_err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: scoreboard of expected words pushed
// on input transfer and popped on output transfer.
module tb_inst_encoder;

  localparam int CNT_W = 16;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [5:0]       i_format;
  logic [6:0]       i_opcode;
  logic [4:0]       i_rd;
  logic [4:0]       i_rs1;
  logic [4:0]       i_rs2;
  logic [2:0]       i_funct3;
  logic [6:0]       i_funct7;
  logic [31:0]      i_imm;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_inst;
  logic             o_err;
  logic [CNT_W-1:0] o_count;
  logic [CNT_W-1:0] o_err_count;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_format    (i_format),
    .i_opcode    (i_opcode),
    .i_rd        (i_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_funct3    (i_funct3),
    .i_funct7    (i_funct7),
    .i_imm       (i_imm),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_inst      (o_inst),
    .o_err       (o_err),
    .o_count     (o_count),
    .o_err_count (o_err_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference encoder built from shifts and masks.
  function automatic logic [31:0] model(input int fmt, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
    case (fmt)
      0: w = w | (32'(f7) << 25);
      1: w = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
      2: w = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
             | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      3: w = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
             | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
             | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      4: w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
      default: w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 20) & 32'h1) << 31);
    endcase
    return w;
  endfunction

  task automatic tick;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [5:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    i_format = fmt; i_opcode = op; i_rd = rd; i_rs1 = rs1;
    i_rs2 = rs2; i_funct3 = f3; i_funct7 = f7; i_imm = imm;
  endtask

  task automatic apply_reset;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(6'b000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(6'b000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_inst !== 32'h0 || o_err !== 1'b0 ||
        o_count !== 16'd0 || o_err_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b inst=%h err=%b cnt=%0d errcnt=%0d, want 0/0/0/0/0",
               o_valid, o_inst, o_err, o_count, o_err_count);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: o_ready=%b want 1", o_ready);
    end
    exp_q.delete();
  endtask

  // Single words with fixed latency: accept at edge N, valid after edge N+1.
  task automatic test_basic;
    logic [31:0] want [4];
    exp_t e;
    want[0] = 32'h0050_0093;
    want[1] = 32'h0020_A423;
    want[2] = 32'h0080_00EF;
    want[3] = 32'h1234_52B7;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
        1: drive(6'b000100, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8);
        2: drive(6'b100000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8);
        default: drive(6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000);
      endcase
      i_valid = 1'b1;
      i_ready = 1'b1;
      exp_q.push_back('{inst: want[k], err: 1'b0});
      tick();
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_latency_early[%0d]: o_valid=%b want 0", k, o_valid);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_inst !== e.inst || o_err !== e.err) begin
        failures++;
        $display("FAIL basic_word[%0d]: valid=%b inst=%h err=%b want 1/%h/%b",
                 k, o_valid, o_inst, o_err, e.inst, e.err);
      end
      tick();
      checks++;
      if (o_count !== 16'(k + 1) || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_count[%0d]: count=%0d valid=%b want %0d/0", k, o_count, o_valid, k + 1);
      end
    end
  endtask

  // Ten words back to back with a three-cycle consumer stall mid-burst.
  task automatic test_back_to_back;
    int   idx_in;
    int   got;
    int   cyc;
    logic saw_full;
    logic [31:0] imm;
    int   fmt;
    exp_t e;
    apply_reset();
    idx_in = 0; got = 0; cyc = 0; saw_full = 1'b0;
    while ((idx_in < 10 || exp_q.size() > 0) && cyc < 200) begin
      i_ready = !(cyc >= 4 && cyc < 7);
      fmt = idx_in % 6;
      imm = (fmt == 4) ? (32'(idx_in + 1) << 12) : (32'(idx_in) * 32'd8);
      if (idx_in < 10) begin
        drive(6'b000001 << fmt, 7'(7'h03 + idx_in), 5'(idx_in + 1), 5'(idx_in + 2),
              5'(idx_in + 3), 3'(idx_in), 7'(idx_in * 5), imm);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected: inst=%h with empty scoreboard", o_inst);
        end else if (o_inst !== exp_q[0].inst || o_err !== exp_q[0].err) begin
          failures++;
          $display("FAIL b2b_word[%0d] cyc=%0d: inst=%h err=%b want %h/%b",
                   got, cyc, o_inst, o_err, exp_q[0].inst, exp_q[0].err);
        end
      end
      if (i_valid && !o_ready) saw_full = 1'b1;
      if (o_valid && i_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back('{inst: model(fmt, 7'(7'h03 + idx_in), 5'(idx_in + 1), 5'(idx_in + 2),
                                      5'(idx_in + 3), 3'(idx_in), 7'(idx_in * 5), imm),
                          err: 1'b0});
        idx_in++;
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (got !== 10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got=%0d pending=%0d want 10/0", got, exp_q.size());
    end
    checks++;
    if (o_count !== 16'd10) begin
      failures++;
      $display("FAIL b2b_count: count=%0d want 10", o_count);
    end
    checks++;
    if (saw_full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_backpressure: o_ready never dropped, want a drop");
    end
  endtask

  // Malformed format plus immediates that only the range check rejects.
  task automatic test_errors;
    int   idx_in;
    int   cyc;
    logic range_on;
    exp_t e;
`ifdef INST_ENCODER_RANGE_CHECK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    apply_reset();
    idx_in = 0; cyc = 0;
    i_ready = 1'b1;
    while ((idx_in < 3 || exp_q.size() > 0) && cyc < 50) begin
      case (idx_in)
        0: drive(6'b000110, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
        1: drive(6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3);
        default: drive(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096);
      endcase
      i_valid = (idx_in < 3);
      #1;
      if (o_valid && i_ready) begin
        checks++;
        e = exp_q.pop_front();
        if (o_inst !== e.inst || o_err !== e.err) begin
          failures++;
          $display("FAIL err_word: inst=%h err=%b want %h/%b", o_inst, o_err, e.inst, e.err);
        end
      end
      if (i_valid && o_ready) begin
        case (idx_in)
          0: exp_q.push_back('{inst: 32'h0020_81B3, err: 1'b1});
          1: exp_q.push_back('{inst: 32'h0020_8163, err: range_on});
          default: exp_q.push_back('{inst: 32'h0000_0093, err: range_on});
        endcase
        idx_in++;
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    checks++;
    if (o_count !== 16'd3 || o_err_count !== (range_on ? 16'd3 : 16'd1)) begin
      failures++;
      $display("FAIL err_counts: count=%0d errcnt=%0d want 3/%0d",
               o_count, o_err_count, range_on ? 3 : 1);
    end
  endtask

  // Reset with two words in flight, then a clean restart.
  task automatic test_reset_midstream;
    apply_reset();
    drive(6'b000010, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
    i_valid = 1'b1;
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(6'b000010, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
    tick();
    drive(6'b000010, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd11);
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_count !== 16'd1 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_prefill: valid=%b count=%0d ready=%b want 1/1/0", o_valid, o_count, o_ready);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 16'd0 || o_err_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b count=%0d errcnt=%0d want 0/0/0", o_valid, o_count, o_err_count);
    end
    tick();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    drive(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_inst !== 32'h0050_0093 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart: valid=%b inst=%h err=%b want 1/00500093/0", o_valid, o_inst, o_err);
    end
    tick();
    checks++;
    if (o_count !== 16'd1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart_count: count=%0d valid=%b want 1/0", o_count, o_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(6'b000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: field bundle (opcode, registers, funct, immediate, format) in, 32-bit instruction word out.
- Inverse of the decoder's immediate extraction: scatters a 32-bit immediate into the format-specific bit positions.
- Two-stage valid/ready pipeline.
- Used by the self-checking CPU bench and the program-image generator to build instruction streams on the fly.

Parameters:
- CNT_W, 16, width of the encoded-word and error counters.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input bundle valid.
- o_ready  output  1  encoder can accept the bundle this cycle.
- i_format  input  6  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J.
- i_opcode  input  7  opcode, placed at inst[6:0].
- i_rd  input  5  destination register, inst[11:7] (R/I/U/J).
- i_rs1  input  5  source 1, inst[19:15] (R/I/S/B).
- i_rs2  input  5  source 2, inst[24:20] (R/S/B).
- i_funct3  input  3  inst[14:12] (R/I/S/B).
- i_funct7  input  7  inst[31:25] (R only).
- i_imm  input  32  signed immediate value (byte offset for B/J; already-shifted value for U).
- o_valid  output  1  encoded word valid.
- i_ready  input  1  consumer accepts the word.
- o_inst  output  32  encoded instruction.
- o_err  output  1  sideband with o_inst: bundle failed checks.
- o_count  output  CNT_W  words emitted, wrapping.
- o_err_count  output  CNT_W  words emitted with o_err=1, saturating at all-ones.

Behaviour:
- Reset (async assert, sync release): all valids 0, o_inst 0, o_err 0, both counters 0. o_ready is 1 from the first cycle after release.
- Handshake:
  - Transfer in on i_valid && o_ready; transfer out on o_valid && i_ready.
  - A stage advances when it is empty or the stage ahead advances.
  - o_ready = !s1_valid || s1_adv.
  - Full throughput of 1 word/cycle.
  - Latency: bundle accepted at edge N appears on o_valid/o_inst after edge N+1.
  - o_inst and o_err hold stable while o_valid && !i_ready.
- Stage 1:
  - Registers the bundle.
  - Computes the format-error flag: i_format not exactly one-hot → error; output word then is {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode} (R layout).
- Stage 2 assembly:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Out-of-range immediate bits are truncated silently, except where range checking flags them (Optional Feature).
- Counters:
  - o_count increments on each output transfer.
  - o_err_count increments on each output transfer with o_err=1.
  - Both update at the same edge as the transfer.
- Simultaneous events: input and output transfers in one cycle with the pipeline full → both stages shift, no bubble, no loss.
- Reset mid-stream: in-flight words are dropped; no partial word is ever presented.

Optional Feature:
- Macro: INST_ENCODER_RANGE_CHECK_EN.
- Defined: stage 1 also flags an immediate not representable in the format:
  - I/S: imm[31:11] not all-equal.
  - B: imm[31:12] not all-equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - J: imm[31:20] not all-equal, or imm[0]=1.
  - R: never flagged.
- Not defined: only the one-hot format check drives o_err.
- Encoding of o_inst is identical either way.

Decomposition:
- Shared package holds:
  - Format index constants (FMT_R=0 … FMT_J=5) and format width 6, also used by the decoder.
  - Opcode constants (OP_IMM, STORE, BRANCH, LUI, JAL, …).
- One sub-module: inst_encoder_pack, purely combinational field-to-word assembly used in stage 2. The pipeline and counters stay in the top.

Test Plan:
- addi x1,x0,5 (I, opcode 0x13, rd=1, imm=5) → o_inst=0x00500093 two edges after accept, o_err=0, o_count=1.
- sw x2,8(x1) (S, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8) → 0x0020A423.
- jal x1,8 (J, opcode 0x6F) → 0x008000EF. lui x5,0x12345000 (U, opcode 0x37) → 0x123452B7.
- Ten back-to-back bundles with i_ready held low 3 cycles mid-burst:
  - o_ready drops once both stages are full.
  - o_inst is stable while stalled.
  - All 10 words arrive in order.
  - o_count=10.
- Error cases:
  - i_format=6'b000110 → o_err=1, o_err_count=1.
  - With INST_ENCODER_RANGE_CHECK_EN: B-type imm=3 → o_err=1; I-type imm=4096 → o_err=1.
  - Without INST_ENCODER_RANGE_CHECK_EN: B-type imm=3 and I-type imm=4096 → o_err=0.
- Assert i_rst_n low with 2 words in flight:
  - o_valid=0 and counters 0 immediately.
  - After release, the first accepted bundle emits normally.
